// File: rtl/karatsuba_recombine_seq.sv
// Karatsuba recombination: k1*B^2 + (k3-k2-k1)*B + k2 with B = 2^HALF, computed
// over four cycles on one shared 64-bit adder built from 16-bit Kogge-Stone slices.
module karatsuba_recombine_seq #(
  parameter int HALF = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_k1,
  input  logic [63:0] in_k2,
  input  logic [63:0] in_k3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [64:0] out_result,
  output logic        out_neg,
  output logic        out_ovf
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SUB1 = 3'd1,
    SUB2 = 3'd2,
    ADD1 = 3'd3,
    ADD2 = 3'd4,
    DONE = 3'd5
  } state_t;

  // 16-bit Kogge-Stone slice; cin is folded into the bit-0 generate term.
  function automatic logic [16:0] ks16(input logic [15:0] a, input logic [15:0] b,
                                       input logic cin);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] pp;
    logic [15:0] g_n;
    logic [15:0] pp_n;
    p     = a ^ b;
    g     = a & b;
    g[0]  = g[0] | (p[0] & cin);
    pp    = p;
    for (int d = 1; d < 16; d = d * 2) begin
      g_n  = g;
      pp_n = pp;
      for (int i = d; i < 16; i++) begin
        g_n[i]  = g[i] | (pp[i] & g[i-d]);
        pp_n[i] = pp[i] & pp[i-d];
      end
      g  = g_n;
      pp = pp_n;
    end
    return {g[15], p ^ {g[14:0], cin}};
  endfunction

  // Four slices with ripple carry between them; returns {cout, sum}.
  function automatic logic [64:0] add64(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin);
    logic [16:0] s0;
    logic [16:0] s1;
    logic [16:0] s2;
    logic [16:0] s3;
    s0 = ks16(a[15:0],  b[15:0],  cin);
    s1 = ks16(a[31:16], b[31:16], s0[16]);
    s2 = ks16(a[47:32], b[47:32], s1[16]);
    s3 = ks16(a[63:48], b[63:48], s2[16]);
    return {s3[16], s3[15:0], s2[15:0], s1[15:0], s0[15:0]};
  endfunction

  state_t      r_state;
  logic [63:0] r_k1;
  logic [63:0] r_k2;
  logic [63:0] r_k3;
  logic [63:0] r_acc;
  logic        r_c1;
  logic        r_neg;
  logic        r_ovf;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [64:0] r_result;

  logic [63:0] w_a;
  logic [63:0] w_b;
  logic        w_cin;
  logic [64:0] w_sum;
  logic [63:0] w_k1_sh;
  logic [63:0] w_mid_sh;
  logic        w_lost;

  // r_acc holds t after SUB1, mid after SUB2 and s1 after ADD1.
  assign w_k1_sh  = r_k1 << (2 * HALF);
  assign w_mid_sh = r_acc << HALF;
  assign w_lost   = (|(r_k1 >> (64 - 2 * HALF))) | (|(r_acc >> (64 - HALF)));
  assign w_sum    = add64(w_a, w_b, w_cin);

  // Shared adder operand selection per arithmetic step.
  always_comb begin
    w_a   = 64'd0;
    w_b   = 64'd0;
    w_cin = 1'b0;
    case (r_state)
      SUB1: begin
        w_a   = r_k3;
        w_b   = ~r_k1;
        w_cin = 1'b1;
      end
      SUB2: begin
        w_a   = r_acc;
        w_b   = ~r_k2;
        w_cin = 1'b1;
      end
      ADD1: begin
        w_a   = w_k1_sh;
        w_b   = w_mid_sh;
        w_cin = 1'b0;
      end
      ADD2: begin
        w_a   = r_acc;
        w_b   = r_k2;
        w_cin = 1'b0;
      end
      default: begin
        w_a   = 64'd0;
        w_b   = 64'd0;
        w_cin = 1'b0;
      end
    endcase
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_k1        <= 64'd0;
      r_k2        <= 64'd0;
      r_k3        <= 64'd0;
      r_acc       <= 64'd0;
      r_c1        <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= 65'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_k1       <= in_k1;
            r_k2       <= in_k2;
            r_k3       <= in_k3;
            r_neg      <= 1'b0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= SUB1;
          end
        end
        SUB1: begin
          r_acc   <= w_sum[63:0];
          r_neg   <= ~w_sum[64];
          r_state <= SUB2;
        end
        SUB2: begin
          r_acc   <= w_sum[63:0];
          r_neg   <= r_neg | ~w_sum[64];
          r_state <= ADD1;
        end
        ADD1: begin
          r_acc   <= w_sum[63:0];
          r_c1    <= w_sum[64];
          r_ovf   <= r_ovf | w_lost;
          r_state <= ADD2;
        end
        ADD2: begin
          // {c1,64'b0} + {c2,s2} mod 2^65 only touches bit 64.
          r_result    <= {r_c1 ^ w_sum[64], w_sum[63:0]};
          r_ovf       <= r_ovf | (r_c1 & w_sum[64]);
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign out_neg    = r_neg;
  assign out_ovf    = r_ovf;

endmodule

// File: tb/tb_karatsuba_recombine_seq.sv
// Scoreboard bench for karatsuba_recombine_seq: directed triples with hand-computed
// results, backpressure, back-to-back spacing and reset in the middle of a computation.
module tb_karatsuba_recombine_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_k1;
  logic [63:0] in_k2;
  logic [63:0] in_k3;
  logic        out_valid;
  logic        out_ready;
  logic [64:0] out_result;
  logic        out_neg;
  logic        out_ovf;

  karatsuba_recombine_seq #(.HALF(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_k1      (in_k1),
    .in_k2      (in_k2),
    .in_k3      (in_k3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_neg    (out_neg),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [64:0] res;
    logic        neg;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  bit   seen_valid = 1'b0;

  function automatic exp_t mk(input logic [64:0] res, input logic neg, input logic ovf);
    exp_t e;
    e.res = res;
    e.neg = neg;
    e.ovf = ovf;
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: latency on first sight of out_valid, result compare on handshake.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      seen_valid = 1'b0;
    end else begin
      if (out_valid && !seen_valid) begin
        seen_valid = 1'b1;
        if (acc_q.size() > 0) begin
          int a;
          a = acc_q.pop_front();
          check("latency", 128'(cyc + 1 - a), 128'd5);
        end else begin
          fail_now("unexpected_out_valid");
        end
      end
      if (out_valid && out_ready) begin
        seen_valid = 1'b0;
        if (exp_q.size() == 0) begin
          fail_now("result_without_request");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_result", 128'(out_result), 128'(e.res));
          check("out_neg", 128'(out_neg), 128'(e.neg));
          check("out_ovf", 128'(out_ovf), 128'(e.ovf));
        end
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input exp_t e, output int acc_edge);
    int n;
    bit ok;
    n        = 0;
    ok       = 1'b0;
    acc_edge = -1;
    in_k1    = a;
    in_k2    = b;
    in_k3    = c;
    in_valid = 1'b1;
    while (!ok && n < 60) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      fail_now("accept_timeout");
    end else begin
      acc_edge = cyc + 1;
      exp_q.push_back(e);
      acc_q.push_back(acc_edge);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  logic [63:0] vk1 [4];
  logic [63:0] vk2 [4];
  logic [63:0] vk3 [4];
  exp_t        vex [4];
  int          e0, e1, e2;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_k1     = 64'd0;
    in_k2     = 64'd0;
    in_k3     = 64'd0;

    vk1[0] = 64'd21;          vk2[0] = 64'd10; vk3[0] = 64'd72;
    vex[0] = mk(65'h15_0029_000A, 1'b0, 1'b0);
    vk1[1] = 64'd5;           vk2[1] = 64'd5;  vk3[1] = 64'd3;
    vex[1] = mk(65'h1_0000_0004_FFF9_0005, 1'b1, 1'b1);
    vk1[2] = 64'h1_0000_0000; vk2[2] = 64'd0;  vk3[2] = 64'h1_0000_0000;
    vex[2] = mk(65'd0, 1'b0, 1'b1);
    vk1[3] = 64'hFFFF_FFFF;   vk2[3] = 64'd0;  vk3[3] = 64'hFFFF_FFFF;
    vex[3] = mk(65'hFFFF_FFFF_0000_0000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_result", 128'(out_result), 128'd0);
    check("rst_out_neg", 128'(out_neg), 128'd0);
    check("rst_out_ovf", 128'(out_ovf), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_out_ready_no_effect", 128'(out_valid), 128'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      send(vk1[i], vk2[i], vk3[i], vex[i], e0);
      in_valid = 1'b0;
      drain();
    end

    // Backpressure: DONE must hold for 10 cycles with stable outputs.
    out_ready = 1'b0;
    send(64'd21, 64'd10, 64'd72, vex[0], e0);
    in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) fail_now("bp_wait_valid");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_result", 128'(out_result), 128'h15_0029_000A);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_valid", 128'(out_valid), 128'd0);
    check("bp_release_ready", 128'(in_ready), 128'd1);
    drain();

    // Back-to-back with in_valid held high.
    send(vk1[0], vk2[0], vk3[0], vex[0], e0);
    send(vk1[3], vk2[3], vk3[3], vex[3], e1);
    send(64'h10, 64'h20, 64'h50, mk(65'h10_0020_0020, 1'b0, 1'b0), e2);
    in_valid = 1'b0;
    check("b2b_spacing_1", 128'(e1 - e0), 128'd6);
    check("b2b_spacing_2", 128'(e2 - e1), 128'd6);
    drain();

    // Reset while in ADD1 discards the triple.
    send(64'd21, 64'd10, 64'd72, vex[0], e0);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_out_result", 128'(out_result), 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_flags", 128'({out_neg, out_ovf}), 128'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(64'd21, 64'd10, 64'd72, vex[0], e0);
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
